alu_cmd_driver: RTL and testbench

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

---
 rtl/alu_cmd_if.sv | 27 ++
 rtl/alu_cmd_driver.sv | 127 ++++++++++++
 tb/tb_alu_cmd_driver.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_if.sv
// Command/ALU/response bundle for alu_cmd_driver.
// slave = the driver itself, master = whoever supplies commands, the ALU and the consumer.
interface alu_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_a;
    logic [2:0] cmd_b;
    logic [7:0] alu_in;
    logic [7:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_data;
    logic       rsp_dz;
    logic       rsp_err;
    logic       busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, rsp_ready,
        output cmd_ready, alu_in, rsp_valid, rsp_data, rsp_dz, rsp_err, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, rsp_ready,
        input  cmd_ready, alu_in, rsp_valid, rsp_data, rsp_dz, rsp_err, busy
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Single-outstanding command driver for an external ALU: issue, settle, capture, respond.
// Optional macro ALU_ECHO_CHECK_EN flags responses whose echoed opcode does not match.
module alu_cmd_driver #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_cmd_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);
    localparam logic [1:0] OP_DIV      = 2'b11;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [7:0] alu_in_q;
    logic [5:0] rsp_data_q;
    logic       rsp_dz_q;
    logic       rsp_valid_q;
    logic       cmd_ready_q;
    logic       busy_q;
    logic       div_by_zero;

    assign div_by_zero = (bus.cmd_op == OP_DIV) && (bus.cmd_b == 3'd0);

`ifdef ALU_ECHO_CHECK_EN
    logic [1:0] op_q;
    logic       rsp_err_q;
    assign bus.rsp_err = rsp_err_q;
`else
    // Echo bits are intentionally ignored in this build.
    logic unused_echo;
    assign unused_echo = ^bus.alu_out[7:6];
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            alu_in_q    <= 8'h00;
            rsp_data_q  <= 6'd0;
            rsp_dz_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef ALU_ECHO_CHECK_EN
            op_q        <= 2'b00;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (div_by_zero) begin
                            // Never reaches the ALU; answer immediately.
                            rsp_data_q  <= 6'd0;
                            rsp_dz_q    <= 1'b1;
                            rsp_valid_q <= 1'b1;
`ifdef ALU_ECHO_CHECK_EN
                            rsp_err_q   <= 1'b0;
`endif
                            state_q     <= RESP;
                        end else begin
                            alu_in_q <= {bus.cmd_op, bus.cmd_b, bus.cmd_a};
`ifdef ALU_ECHO_CHECK_EN
                            op_q     <= bus.cmd_op;
`endif
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= SETTLE_LOAD;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                CAPTURE: begin
                    rsp_data_q  <= bus.alu_out[5:0];
                    rsp_dz_q    <= 1'b0;
`ifdef ALU_ECHO_CHECK_EN
                    rsp_err_q   <= (bus.alu_out[7:6] != op_q);
`endif
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_in    = alu_in_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_dz    = rsp_dz_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: directed vectors, random traffic, backpressure, mid-flight reset.
module tb_alu_cmd_driver;
    localparam int SC = 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] last_alu;

    alu_cmd_if bus_if ();

    alu_cmd_driver #(.SETTLE_CYCLES(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: echoes opcode except for mul, where it returns 00.
    always_comb begin
        logic [7:0] r;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        op = bus_if.alu_in[7:6];
        a  = {5'd0, bus_if.alu_in[2:0]};
        b  = {5'd0, bus_if.alu_in[5:3]};
        r  = 8'd0;
        case (op)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: r = a * b;
            default: r = (b == 8'd0) ? 8'hFF : a / b;
        endcase
        bus_if.alu_out = {(op == 2'b10) ? 2'b00 : op, r[5:0]};
    end

    function automatic int model_result(input int op, input int a, input int b);
        int v;
        case (op)
            0: v = a + b;
            1: v = a - b + 256;
            2: v = a * b;
            default: v = (b == 0) ? 0 : a / b;
        endcase
        return (v % 256) % 64;
    endfunction

    task automatic do_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b, input int stall);
        int         n;
        int         edges;
        int         exp_lat;
        logic       exp_dz;
        logic       exp_err;
        logic [5:0] exp_data;
        logic [7:0] exp_alu;
        logic [5:0] held;
        exp_dz   = (op == 2'b11) && (b == 3'd0);
        exp_data = 6'(model_result(int'(op), int'(a), int'(b)));
`ifdef ALU_ECHO_CHECK_EN
        exp_err  = (op == 2'b10);
`else
        exp_err  = 1'b0;
`endif
        exp_lat  = exp_dz ? 1 : 3 + SC;
        exp_alu  = exp_dz ? last_alu : {op, b, a};

        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = op;
        bus_if.cmd_a     = a;
        bus_if.cmd_b     = b;
        bus_if.rsp_ready = 1'b0;
        n = 0;
        while (!bus_if.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: got %b want 1", bus_if.cmd_ready);
        end
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 2'($urandom);
        bus_if.cmd_a     = 3'($urandom);
        bus_if.cmd_b     = 3'($urandom);
        edges = 1;
        while (!bus_if.rsp_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        n_checks++;
        if (edges !== exp_lat) begin
            n_fail++;
            $display("FAIL latency: got %0d want %0d", edges, exp_lat);
        end
        n_checks++;
        if (bus_if.alu_in !== exp_alu) begin
            n_fail++;
            $display("FAIL alu_in: got %h want %h", bus_if.alu_in, exp_alu);
        end
        n_checks++;
        if (bus_if.rsp_data !== exp_data) begin
            n_fail++;
            $display("FAIL rsp_data: got %h want %h", bus_if.rsp_data, exp_data);
        end
        n_checks++;
        if (bus_if.rsp_dz !== exp_dz) begin
            n_fail++;
            $display("FAIL rsp_dz: got %b want %b", bus_if.rsp_dz, exp_dz);
        end
        n_checks++;
        if (bus_if.rsp_err !== exp_err) begin
            n_fail++;
            $display("FAIL rsp_err: got %b want %b", bus_if.rsp_err, exp_err);
        end
        last_alu = exp_alu;
        held = bus_if.rsp_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_data !== held ||
                bus_if.cmd_ready !== 1'b0 || bus_if.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure: got valid=%b data=%h ready=%b busy=%b want 1 %h 0 1",
                         bus_if.rsp_valid, bus_if.rsp_data, bus_if.cmd_ready, bus_if.busy, held);
            end
        end
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
        n_checks++;
        if (bus_if.rsp_valid !== 1'b0 || bus_if.cmd_ready !== 1'b1 || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL consume: got valid=%b ready=%b busy=%b want 0 1 0",
                     bus_if.rsp_valid, bus_if.cmd_ready, bus_if.busy);
        end
        $display("txn op=%0d a=%0d b=%0d data=%h dz=%b err=%b lat=%0d stall=%0d",
                 op, a, b, held, exp_dz, exp_err, edges, stall);
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 2'd0;
        bus_if.cmd_a     = 3'd0;
        bus_if.cmd_b     = 3'd0;
        bus_if.rsp_ready = 1'b0;
        last_alu         = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus_if.alu_in !== 8'h00 || bus_if.rsp_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got alu_in=%h valid=%b busy=%b want 00 0 0",
                     bus_if.alu_in, bus_if.rsp_valid, bus_if.busy);
        end
        n_checks++;
        if (bus_if.rsp_data !== 6'd0 || bus_if.rsp_dz !== 1'b0 || bus_if.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: got data=%h dz=%b err=%b want 00 0 0",
                     bus_if.rsp_data, bus_if.rsp_dz, bus_if.rsp_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", bus_if.cmd_ready);
        end
        $display("txn reset released");
    endtask

    task automatic test_directed();
        do_cmd(2'b00, 3'd3, 3'd5, 0);
        do_cmd(2'b01, 3'd2, 3'd5, 0);
        do_cmd(2'b10, 3'd7, 3'd7, 0);
        do_cmd(2'b11, 3'd6, 3'd0, 0);
        do_cmd(2'b11, 3'd7, 3'd2, 0);
    endtask

    task automatic test_backpressure();
        do_cmd(2'b00, 3'd7, 3'd6, 5);
        do_cmd(2'b11, 3'd1, 3'd0, 5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_cmd(2'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom),
                   int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            do_cmd(2'(i % 4), 3'(i + 1), 3'(7 - i), 0);
        end
    endtask

    task automatic test_reset_mid_settle();
        int spurious;
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = 2'b00;
        bus_if.cmd_a     = 3'd4;
        bus_if.cmd_b     = 3'd4;
        bus_if.rsp_ready = 1'b0;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.alu_in !== 8'h00 || bus_if.busy !== 1'b0 || bus_if.rsp_valid !== 1'b0 ||
            bus_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_async: got alu_in=%h busy=%b valid=%b ready=%b want 00 0 0 1",
                     bus_if.alu_in, bus_if.busy, bus_if.rsp_valid, bus_if.cmd_ready);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        last_alu = 8'h00;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid !== 1'b0 || bus_if.busy !== 1'b0) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL midreset_noresp: got %0d active cycles want 0", spurious);
        end
        $display("txn reset mid-settle");
        do_cmd(2'b01, 3'd5, 3'd1, 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
